// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
//   Multi-cycle MIPS subset core: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
//   Internal 32x32 register file. Instruction and data memories are external
//   synchronous RAMs, so read data returns one cycle after the address.
//
//   Optional build macro: MIPS_OVF_TRAP_EN
//     When defined, signed overflow on add/addi/sub suppresses writeback,
//     sets the sticky o_ovf flag and redirects the PC to TRAP_VEC.
//     When undefined, there is no o_ovf port and add/addi/sub wrap like
//     addu/addiu/subu.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   nrst          synchronous, active-low reset
//   o_imem_addr   instruction word address (pc[PC_W-1:2])
//   i_imem_rdata  instruction word, valid one cycle after o_imem_addr
//   o_dmem_addr   data word address (alu_result[DADDR_W+1:2])
//   o_dmem_wdata  store data (rt value)
//   o_dmem_we     byte write enables, 4'b1111 only in the MEM cycle of sw
//   i_dmem_rdata  load data, valid one cycle after o_dmem_addr
//   o_pc          current PC
//   o_state       FSM state code (FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4)
//   o_retire      pulse on the last cycle of each instruction
//   o_reg_din     last writeback data
//   o_illegal     sticky flag, set by an unsupported opcode/funct
//   o_ovf         sticky overflow-trap flag (MIPS_OVF_TRAP_EN only)
//
// Memory handshake: there is no valid/ready; the core drives an address in
// one state and consumes the RAM read data in the following state.

module mips_multicycle_core #(
  parameter int              PC_W     = 8,
  parameter int              DADDR_W  = 6,
  parameter logic [PC_W-1:0] TRAP_VEC = '0
) (
  input  logic               clk,
  input  logic               nrst,
  output logic [PC_W-3:0]    o_imem_addr,
  input  logic [31:0]        i_imem_rdata,
  output logic [DADDR_W-1:0] o_dmem_addr,
  output logic [31:0]        o_dmem_wdata,
  output logic [3:0]         o_dmem_we,
  input  logic [31:0]        i_dmem_rdata,
  output logic [PC_W-1:0]    o_pc,
  output logic [2:0]         o_state,
  output logic               o_retire,
  output logic [31:0]        o_reg_din,
  output logic               o_illegal
`ifdef MIPS_OVF_TRAP_EN
  ,
  output logic               o_ovf
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_ILL
  } kind_t;

  typedef enum logic [2:0] {
    A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_SLT, A_SLTU, A_LUI
  } aluop_t;

  typedef enum logic [1:0] {
    B_REG, B_SEXT, B_ZEXT
  } bsel_t;

  typedef struct packed {
    kind_t  kind;
    aluop_t op;
    bsel_t  bsel;
    logic   wr_rd;   // destination is rd (R-type) rather than rt
  } dec_t;

  // Instruction class only; used both for full decode and for the early
  // retire decision made while the instruction word arrives.
  function automatic kind_t kind_of(input logic [31:0] instr);
    kind_t k;
    case (instr[31:26])
      6'h00: begin
        case (instr[5:0])
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
          6'h25, 6'h26, 6'h2A, 6'h2B: k = K_ALU;
          default:                    k = K_ILL;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0C,
      6'h0D, 6'h0E, 6'h0F: k = K_ALU;
      6'h23:               k = K_LW;
      6'h2B:               k = K_SW;
      6'h04:               k = K_BEQ;
      6'h05:               k = K_BNE;
      6'h02:               k = K_J;
      default:             k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.kind  = kind_of(instr);
    d.op    = A_ADD;
    d.bsel  = B_REG;
    d.wr_rd = 1'b0;
    case (instr[31:26])
      6'h00: begin
        d.wr_rd = 1'b1;
        case (instr[5:0])
          6'h22, 6'h23: d.op = A_SUB;
          6'h24:        d.op = A_AND;
          6'h25:        d.op = A_OR;
          6'h26:        d.op = A_XOR;
          6'h2A:        d.op = A_SLT;
          6'h2B:        d.op = A_SLTU;
          default:      d.op = A_ADD;
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2B: d.bsel = B_SEXT;
      6'h0A: begin d.op = A_SLT; d.bsel = B_SEXT; end
      6'h0C: begin d.op = A_AND; d.bsel = B_ZEXT; end
      6'h0D: begin d.op = A_OR;  d.bsel = B_ZEXT; end
      6'h0E: begin d.op = A_XOR; d.bsel = B_ZEXT; end
      6'h0F: d.op = A_LUI;
      default: ;
    endcase
    return d;
  endfunction

  // Registered state
  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [31:0]     r_alu;
  logic [31:0]     r_reg_din;
  logic [3:0]      r_dmem_we;
  logic            r_retire;
  logic            r_illegal;
  logic [31:0]     r_rf [32];

  // Combinational datapath
  dec_t            w_dec;
  kind_t           w_kind_in;
  logic            w_short_in;
  logic [31:0]     w_opb;
  logic [31:0]     w_sum;
  logic [31:0]     w_diff;
  logic [31:0]     w_alu;
  logic [PC_W-1:0] w_pc_seq;
  logic [PC_W-1:0] w_br_tgt;
  logic [PC_W-1:0] w_j_tgt;
  logic [PC_W-1:0] w_wb_pc;
  logic [4:0]      w_wb_dst;
  logic [31:0]     w_wb_data;
  logic            w_wb_en;
  logic            w_trap;

  assign w_dec     = decode(r_ir);
  assign w_kind_in = kind_of(i_imem_rdata);
  // Branches, jump and illegal instructions finish in EXEC.
  assign w_short_in = (w_kind_in == K_BEQ) || (w_kind_in == K_BNE) ||
                      (w_kind_in == K_J)   || (w_kind_in == K_ILL);

  always_comb begin
    case (w_dec.bsel)
      B_SEXT:  w_opb = {{16{r_ir[15]}}, r_ir[15:0]};
      B_ZEXT:  w_opb = {16'h0000, r_ir[15:0]};
      default: w_opb = r_b;
    endcase
  end

  assign w_sum  = r_a + w_opb;
  assign w_diff = r_a - w_opb;

  always_comb begin
    case (w_dec.op)
      A_ADD:   w_alu = w_sum;
      A_SUB:   w_alu = w_diff;
      A_AND:   w_alu = r_a & w_opb;
      A_OR:    w_alu = r_a | w_opb;
      A_XOR:   w_alu = r_a ^ w_opb;
      A_SLT:   w_alu = {31'h0, ($signed(r_a) < $signed(w_opb))};
      A_SLTU:  w_alu = {31'h0, (r_a < w_opb)};
      A_LUI:   w_alu = {r_ir[15:0], 16'h0000};
      default: w_alu = w_sum;
    endcase
  end

  // PC arithmetic is modulo 2^PC_W, so wrap-around falls out of truncation.
  assign w_pc_seq = r_pc + PC_W'(4);
  assign w_br_tgt = w_pc_seq + PC_W'({{14{r_ir[15]}}, r_ir[15:0], 2'b00});
  assign w_j_tgt  = PC_W'({r_ir[25:0], 2'b00});

  assign w_wb_dst  = w_dec.wr_rd ? r_ir[15:11] : r_ir[20:16];
  assign w_wb_data = (w_dec.kind == K_LW) ? i_dmem_rdata : r_alu;

`ifdef MIPS_OVF_TRAP_EN
  logic w_ovf_chk;
  logic w_ovf_now;
  logic r_ovf_pend;
  logic r_ovf;

  // Only the trapping forms (add, addi, sub) are checked.
  assign w_ovf_chk = (r_ir[31:26] == 6'h08) ||
                     ((r_ir[31:26] == 6'h00) &&
                      ((r_ir[5:0] == 6'h20) || (r_ir[5:0] == 6'h22)));
  assign w_ovf_now = (w_dec.op == A_SUB)
                   ? ((r_a[31] != w_opb[31]) && (w_diff[31] != r_a[31]))
                   : ((r_a[31] == w_opb[31]) && (w_sum[31]  != r_a[31]));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (r_state == S_EXEC) r_ovf_pend <= w_ovf_chk & w_ovf_now;
      if ((r_state == S_WB) && r_ovf_pend) r_ovf <= 1'b1;
    end
  end

  assign w_trap = r_ovf_pend;
  assign o_ovf  = r_ovf;
`else
  assign w_trap = 1'b0;
`endif

  assign w_wb_pc = w_trap ? TRAP_VEC : w_pc_seq;
  assign w_wb_en = (r_state == S_WB) && !w_trap && (w_wb_dst != 5'd0);

  // Main FSM, register file and all registered outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state   <= S_FETCH;
      r_pc      <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu     <= '0;
      r_reg_din <= '0;
      r_dmem_we <= 4'b0000;
      r_retire  <= 1'b0;
      r_illegal <= 1'b0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          // Operands are read using fields of the word just returned by IMem.
          r_ir     <= i_imem_rdata;
          r_a      <= r_rf[i_imem_rdata[25:21]];
          r_b      <= r_rf[i_imem_rdata[20:16]];
          r_retire <= w_short_in;
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          r_alu <= w_alu;
          case (w_dec.kind)
            K_BEQ: begin
              r_pc    <= (r_a == r_b) ? w_br_tgt : w_pc_seq;
              r_state <= S_FETCH;
            end
            K_BNE: begin
              r_pc    <= (r_a != r_b) ? w_br_tgt : w_pc_seq;
              r_state <= S_FETCH;
            end
            K_J: begin
              r_pc    <= w_j_tgt;
              r_state <= S_FETCH;
            end
            K_ILL: begin
              r_illegal <= 1'b1;
              r_pc      <= w_pc_seq;
              r_state   <= S_FETCH;
            end
            K_LW: begin
              r_state <= S_MEM;
            end
            K_SW: begin
              r_dmem_we <= 4'b1111;
              r_retire  <= 1'b1;
              r_state   <= S_MEM;
            end
            default: begin
              r_retire <= 1'b1;
              r_state  <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          r_dmem_we <= 4'b0000;
          if (w_dec.kind == K_LW) begin
            r_retire <= 1'b1;
            r_state  <= S_WB;
          end else begin
            r_pc    <= w_pc_seq;
            r_state <= S_FETCH;
          end
        end
        S_WB: begin
          if (w_wb_en) r_rf[w_wb_dst] <= w_wb_data;
          r_reg_din <= w_wb_data;
          r_pc      <= w_wb_pc;
          r_state   <= S_FETCH;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign o_imem_addr  = r_pc[PC_W-1:2];
  assign o_dmem_addr  = r_alu[DADDR_W+1:2];
  assign o_dmem_wdata = r_b;
  assign o_dmem_we    = r_dmem_we;
  assign o_pc         = r_pc;
  assign o_state      = r_state;
  assign o_retire     = r_retire;
  assign o_reg_din    = r_reg_din;
  assign o_illegal    = r_illegal;

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS core.
- Fetch/decode/execute/memory/writeback FSM, internal 32x32 register file, external synchronous instruction and data memory ports.
- Widens the instruction set: R-type ALU ops, immediates, lw/sw, beq/bne, j.
- Sits between the IMem/DMem block-RAM instances and the board-level debug outputs.

Parameters:
- PC_W, 8, program counter width in bits (byte address, 4..28).
- DADDR_W, 6, data memory word-address width.
- TRAP_VEC, 0, PC_W-bit PC loaded on overflow trap (optional feature only).

Ports:
- clk  in  1  clock, all state on rising edge.
- nrst  in  1  reset, synchronous, active-low.
- imem_addr  out  PC_W-2  instruction word address, equal to pc[PC_W-1:2].
- imem_rdata  in  32  instruction word, valid one cycle after imem_addr.
- dmem_addr  out  DADDR_W  data word address, equal to alu_result[DADDR_W+1:2].
- dmem_wdata  out  32  store data (rt value).
- dmem_we  out  4  byte write enables.
- dmem_rdata  in  32  load data, valid one cycle after dmem_addr.
- pc  out  PC_W  current PC.
- state  out  3  FSM state code, for debug.
- retire  out  1  one-cycle pulse on the last cycle of each instruction.
- reg_din  out  32  writeback data, for debug.
- illegal  out  1  sticky flag, set by any unsupported opcode or funct.

Behaviour:
- Reset: when nrst=0 at a clock edge, the following are cleared:
  - pc=0, state=FETCH, IR=0, dmem_we=0, retire=0, illegal=0, reg_din=0.
  - All 32 registers = 0.
  - Reset mid-instruction aborts the instruction with no register or memory write.
- FSM codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- FETCH:
  - imem_addr = pc[PC_W-1:2].
  - Next state DECODE.
- DECODE:
  - IR <= imem_rdata.
  - A <= rf[rs], B <= rf[rt].
  - Next state EXEC.
- EXEC:
  - Computes alu_result into a register.
  - Operand B is B, or sext(imm16) for addi/addiu/slti/lw/sw, or zext(imm16) for andi/ori/xori.
- Supported ops:
  - R-type funct: add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, slt 0x2A, sltu 0x2B.
  - I-type opcodes: addi 0x08, addiu 0x09, slti 0x0A, andi 0x0C, ori 0x0D, xori 0x0E, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
  - J-type: j 0x02.
- All arithmetic is 32-bit modulo 2^32. slt is signed, sltu is unsigned. lui gives {imm16,16'b0}.
- Writeback destination is rd for R-type, rt for I-type. Writes to r0 are discarded; r0 always reads 0.
- Branches and jump (retire in EXEC, 3 cycles total):
  - beq/bne taken: pc <= pc+4 + (sext(imm16)<<2), truncated to PC_W.
  - beq/bne not taken: pc <= pc+4.
  - j: pc <= {instr[25:0],2'b00} truncated to PC_W.
- ALU ops (4 cycles): EXEC -> WB. In WB: rf write, reg_din = alu_result, pc <= pc+4, retire=1.
- lw (5 cycles):
  - MEM drives dmem_addr.
  - WB writes dmem_rdata to rt, reg_din = dmem_rdata.
- sw (4 cycles):
  - MEM drives dmem_addr, dmem_wdata=B, dmem_we=4'b1111 for that one cycle only.
  - pc <= pc+4, retire=1.
- Address bits alu_result[1:0] are ignored (no alignment fault). Address bits above DADDR_W+1 wrap.
- PC wrap-around: pc+4 at max value wraps to 0.
- Illegal opcode/funct: illegal <= 1, no writes, retires in EXEC with pc <= pc+4.
- retire is 0 in every cycle other than the final cycle of an instruction.
- dmem_we is 0 outside the MEM cycle of sw.

Optional Feature:
- Macro: MIPS_OVF_TRAP_EN.
- Defined:
  - Signed overflow on add/addi/sub suppresses writeback.
  - Sets sticky output ovf (extra 1-bit port, reset 0).
  - pc <= TRAP_VEC; retire pulses in the WB cycle.
- Not defined:
  - No ovf port.
  - add/addi/sub behave exactly as addu/addiu/subu.

Test Plan:
- Reset, then hold nrst=0 for 3 cycles mid-lw -> pc=0, state=0, dmem_we=0, all registers read 0 afterwards.
- addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1; sltu r5,r2,r1 -> r3=2, r4=1, r5=0; retire every 4 cycles; pc=0x14.
- sw r3,8(r0); lw r6,8(r0) -> dmem_we=4'b1111 with dmem_addr=2 for exactly one cycle; r6=2; lw takes 5 cycles.
- beq r1,r1,-1 at pc=0x20 -> pc=0x20 every 3 cycles. bne r1,r1,+4 -> pc=0x24. j 0x3F at PC_W=8 -> pc=0xFC.
- addi r0,r0,7; then opcode 0x3F -> r0 still 0; illegal=1 and stays 1; next pc=prev+4.
- With MIPS_OVF_TRAP_EN: lui r1,0x7FFF; ori r1,r1,0xFFFF; addi r2,r1,1 -> ovf=1, r2 unchanged, pc=TRAP_VEC. Without the macro: r2=0x80000000.
